int_ram_loader: RTL and testbench
=================================

# int_ram_loader

Write-side front end for the two-bank intrinsic message RAM. Accepts channel LLRs on a valid/ready stream, fills one bank with a full frame while the decoder reads the other, then hands the filled bank to the decoder (ping-pong). It owns the muxing of both banks' single ports between the loader write path and the decoder read path.

## Interface
Parameters:
- IN_WIDTH, 8: width of the incoming signed LLR.
- DATA_WIDTH, 5: stored LLR width; matches the RAM word.
- ADDR_WIDTH, 8: RAM address width.
- FRAME_LEN, 256: LLRs per frame; 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  LLR sample present.
- in_ready  out  1  loader can accept a sample this cycle.
- in_llr  in  IN_WIDTH  signed LLR.
- ram_addr[0:1]  out  ADDR_WIDTH  per-bank address to the RAM.
- ram_data[0:1]  out  DATA_WIDTH  per-bank write data.
- ram_we[0:1]  out  1  per-bank write enable.
- ram_cs[0:1]  out  1  per-bank chip select.
- frm_valid  out  1  a filled bank is available to the decoder (level).
- frm_bank  out  1  index of the bank owned by the decoder (RAM select).
- frm_release  in  1  decoder finished with frm_bank (1-cycle pulse).
- dec_addr  in  ADDR_WIDTH  decoder read address, routed to bank frm_bank.
- dec_cs  in  1  decoder read chip select, routed to bank frm_bank.

## Operation
- Per-bank state: FREE, FILL, HELD. Pointers: wr_bank (being filled), rd_bank (= frm_bank, next to be or being decoded). Counter wr_addr, range 0..FRAME_LEN-1.
- in_ready = !rst && bank_state[wr_bank] != HELD.
- Accept (in_valid && in_ready), all combinational to the write port in the same cycle: ram_we[wr_bank]=1, ram_cs[wr_bank]=1, ram_addr[wr_bank]=wr_addr, ram_data[wr_bank]=conv(in_llr). State of wr_bank becomes FILL. wr_addr increments.
- Accept with wr_addr==FRAME_LEN-1: wr_bank becomes HELD, wr_addr goes to 0, and wr_bank toggles.
- frm_valid = bank_state[rd_bank]==HELD. While frm_valid is high, bank rd_bank has ram_addr=dec_addr, ram_cs=dec_cs, ram_we=0, and ram_data=0.
- frm_release while frm_valid is high: rd_bank becomes FREE and rd_bank toggles. frm_release while frm_valid is low is ignored.
- A bank that is not HELD and is not being written this cycle has ram_we=0, ram_cs=0, ram_addr=0, ram_data=0.
- Simultaneous last-accept on bank X and release of bank Y: both apply. X≠Y always holds, because X is FILL and Y is HELD.
- Both banks HELD: in_ready=0. Release of rd_bank frees the bank wr_bank points to, and in_ready rises the next cycle.

## Timing
- Reset values: bank states FREE, wr_bank=0, rd_bank=0, wr_addr=0. Outputs during and after reset: frm_valid=0, frm_bank=0, all ram_* = 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Write latency is 0: the RAM samples the write on the same edge that the handshake completes.
- Last accept at edge E: frm_valid is high in the cycle after E. The decoder's first read address is presented no earlier than that cycle, after the last write has landed.
- frm_release at edge E: frm_bank toggles and frm_valid reflects the other bank from the cycle after E.
- Throughput: 1 LLR/cycle sustained while the decoder releases each bank within FRAME_LEN cycles.
- Reset mid-frame: the partial frame is discarded and the RAM contents are not cleared. The next frame starts at bank 0, address 0.

## Configuration
- INT_RAM_LOADER_SAT_EN defined: conv() saturates signed in_llr to the DATA_WIDTH signed range [-(2^(DATA_WIDTH-1)-1), 2^(DATA_WIDTH-1)-1]. The range is symmetric, so the most-negative code is never stored.
- Not defined: conv() takes in_llr[DATA_WIDTH-1:0]. Use this only when IN_WIDTH==DATA_WIDTH.

## Structure
- Shared package ldpc_pkg: bank_state_t enum (FREE/FILL/HELD), NUM_BANKS=2, default LLR width constants.
- One sub-module, int_llr_sat: combinational IN_WIDTH to DATA_WIDTH symmetric saturator. It is instantiated only under INT_RAM_LOADER_SAT_EN.

## Test plan
All scenarios use FRAME_LEN=4, DATA_WIDTH=5, IN_WIDTH=8, saturation enabled.
- Stream 0..3 back-to-back after reset -> ram_we[0] on 4 consecutive cycles at addr 0..3, data 0..3. frm_valid=1, frm_bank=0 the next cycle.
- Stream 8 samples with no release -> bank 1 fills, in_ready=0 after the 8th accept, and samples 9+ are stalled. One frm_release -> in_ready=1 the next cycle, frm_bank=1.
- in_llr=+100, then -100, then -16 -> stored +15, -15, -15.
- Last accept into bank 1 and frm_release of bank 0 in the same cycle -> both banks update, frm_bank=1, frm_valid stays 1.
- Decoder reads with dec_addr=2, dec_cs=1 while bank 1 is filling -> ram_addr[0]=2, ram_cs[0]=1, ram_we[0]=0. Bank 1 write traffic is unaffected.
- rst asserted after 2 accepts -> the next cycle has frm_valid=0 and all ram_* = 0. The next sample writes bank 0 at addr 0.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared types and default widths for the LDPC intrinsic message path.
package ldpc_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILL,
        HELD
    } bank_state_t;

    localparam int NUM_BANKS      = 2;
    localparam int LLR_IN_WIDTH   = 8;
    localparam int LLR_DATA_WIDTH = 5;
    localparam int RAM_ADDR_WIDTH = 8;

endpackage

// File: rtl/int_llr_sat.sv
// int_llr_sat: combinational signed saturator from IN_WIDTH to a symmetric DATA_WIDTH range.
module int_llr_sat #(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 5
) (
    input  logic signed [IN_WIDTH-1:0]   in_llr,
    output logic        [DATA_WIDTH-1:0] out_llr
);

    // The range is symmetric, so the most-negative DATA_WIDTH code is never produced.
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -SAT_MAX;

    always_comb begin
        if (in_llr > SAT_MAX) begin
            out_llr = SAT_MAX[DATA_WIDTH-1:0];
        end else if (in_llr < SAT_MIN) begin
            out_llr = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            out_llr = in_llr[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/int_ram_loader.sv
// int_ram_loader: ping-pong write front end for the two-bank intrinsic message RAM.
// Define INT_RAM_LOADER_SAT_EN to saturate incoming LLRs instead of truncating them.
module int_ram_loader
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH   = LLR_IN_WIDTH,
    parameter int DATA_WIDTH = LLR_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int FRAME_LEN  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_WIDTH-1:0]   in_llr,
    output logic        [ADDR_WIDTH-1:0] ram_addr [0:NUM_BANKS-1],
    output logic        [DATA_WIDTH-1:0] ram_data [0:NUM_BANKS-1],
    output logic                         ram_we   [0:NUM_BANKS-1],
    output logic                         ram_cs   [0:NUM_BANKS-1],
    output logic                         frm_valid,
    output logic                         frm_bank,
    input  logic                         frm_release,
    input  logic        [ADDR_WIDTH-1:0] dec_addr,
    input  logic                         dec_cs
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    bank_state_t           bank_state     [NUM_BANKS];
    bank_state_t           bank_state_nxt [NUM_BANKS];
    logic                  wr_bank, wr_bank_nxt;
    logic                  rd_bank, rd_bank_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic                  accept;
    logic                  do_release;
    logic [DATA_WIDTH-1:0] conv_llr;

`ifdef INT_RAM_LOADER_SAT_EN
    int_llr_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat (
        .in_llr (in_llr),
        .out_llr(conv_llr)
    );
`else
    assign conv_llr = in_llr[DATA_WIDTH-1:0];
    if (IN_WIDTH > DATA_WIDTH) begin : g_unused
        logic unused_llr_msbs;
        assign unused_llr_msbs = ^in_llr[IN_WIDTH-1:DATA_WIDTH];
    end
`endif

    // Outputs are forced idle while rst is high, before the synchronous reset has landed.
    assign in_ready   = !rst && (bank_state[wr_bank] != HELD);
    assign frm_valid  = !rst && (bank_state[rd_bank] == HELD);
    assign frm_bank   = rd_bank & ~rst;
    assign accept     = in_valid && in_ready;
    assign do_release = frm_release && frm_valid;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        bank_state_nxt = bank_state;
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        wr_addr_nxt    = wr_addr;

        if (accept) begin
            if (wr_addr == LAST_ADDR) begin
                bank_state_nxt[wr_bank] = HELD;
                wr_addr_nxt             = '0;
                wr_bank_nxt             = ~wr_bank;
            end else begin
                bank_state_nxt[wr_bank] = FILL;
                wr_addr_nxt             = wr_addr + 1'b1;
            end
        end

        // A release always targets the HELD bank, never the one being filled.
        if (do_release) begin
            bank_state_nxt[rd_bank] = FREE;
            rd_bank_nxt             = ~rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            bank_state <= '{default: FREE};
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_addr    <= '0;
        end else begin
            bank_state <= bank_state_nxt;
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_addr    <= wr_addr_nxt;
        end
    end

    // The decoder owns rd_bank while it is HELD; the loader write path can never
    // target that bank at the same time because in_ready is low in that case.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            ram_addr[b] = '0;
            ram_data[b] = '0;
            ram_we[b]   = 1'b0;
            ram_cs[b]   = 1'b0;
            if (frm_valid && (rd_bank == 1'(b))) begin
                ram_addr[b] = dec_addr;
                ram_cs[b]   = dec_cs;
            end else if (accept && (wr_bank == 1'(b))) begin
                ram_addr[b] = wr_addr;
                ram_data[b] = conv_llr;
                ram_we[b]   = 1'b1;
                ram_cs[b]   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_ram_loader.sv
// tb_int_ram_loader: directed bench with a frame-counting model checked every cycle.
module tb_int_ram_loader;

    localparam int FL = 4;

`ifdef INT_RAM_LOADER_SAT_EN
    localparam logic [4:0] EXP_P100 = 5'd15;
    localparam logic [4:0] EXP_M100 = 5'b10001;
    localparam logic [4:0] EXP_M16  = 5'b10001;
`else
    localparam logic [4:0] EXP_P100 = 5'b00100;
    localparam logic [4:0] EXP_M100 = 5'b11100;
    localparam logic [4:0] EXP_M16  = 5'b10000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_llr;
    logic [7:0] ram_addr [0:1];
    logic [4:0] ram_data [0:1];
    logic       ram_we   [0:1];
    logic       ram_cs   [0:1];
    logic       frm_valid;
    logic       frm_bank;
    logic       frm_release;
    logic [7:0] dec_addr;
    logic       dec_cs;

    int vectors = 0;
    int errors  = 0;

    int_ram_loader #(
        .IN_WIDTH  (8),
        .DATA_WIDTH(5),
        .ADDR_WIDTH(8),
        .FRAME_LEN (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_llr     (in_llr),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_cs     (ram_cs),
        .frm_valid  (frm_valid),
        .frm_bank   (frm_bank),
        .frm_release(frm_release),
        .dec_addr   (dec_addr),
        .dec_cs     (dec_cs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] conv(input logic [7:0] v);
`ifdef INT_RAM_LOADER_SAT_EN
        int s;
        s = int'($signed(v));
        if (s > 15) return 5'd15;
        if (s < -15) return 5'b10001;
        return v[4:0];
`else
        return v[4:0];
`endif
    endfunction

    // Model: totals of samples accepted, frames completed and frames released.
    int   samples  = 0;
    int   frames   = 0;
    int   releases = 0;
    logic acc_m, rel_m;
    logic       e_ready, e_valid, e_bank;
    logic [7:0] e_addr [0:1];
    logic [4:0] e_data [0:1];
    logic       e_we   [0:1];
    logic       e_cs   [0:1];

    always @(negedge clk) begin
        int pending, wb;
        pending = frames - releases;
        wb      = frames % 2;
        for (int b = 0; b < 2; b++) begin
            e_addr[b] = '0; e_data[b] = '0; e_we[b] = 1'b0; e_cs[b] = 1'b0;
        end
        if (rst) begin
            e_ready = 1'b0; e_valid = 1'b0; e_bank = 1'b0;
            acc_m   = 1'b0; rel_m   = 1'b0;
        end else begin
            e_valid = (pending > 0);
            e_bank  = 1'(releases % 2);
            e_ready = (pending < 2);
            acc_m   = in_valid && e_ready;
            rel_m   = frm_release && e_valid;
            for (int b = 0; b < 2; b++) begin
                if (e_valid && b == int'(e_bank)) begin
                    e_addr[b] = dec_addr;
                    e_cs[b]   = dec_cs;
                end else if (acc_m && b == wb) begin
                    e_addr[b] = 8'(samples % FL);
                    e_data[b] = conv(in_llr);
                    e_we[b]   = 1'b1;
                    e_cs[b]   = 1'b1;
                end
            end
        end
        check("in_ready", in_ready, e_ready);
        check("frm_valid", frm_valid, e_valid);
        check("frm_bank", frm_bank, e_bank);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("ram_addr[%0d]", b), ram_addr[b], e_addr[b]);
            check($sformatf("ram_data[%0d]", b), ram_data[b], e_data[b]);
            check($sformatf("ram_we[%0d]", b), ram_we[b], e_we[b]);
            check($sformatf("ram_cs[%0d]", b), ram_cs[b], e_cs[b]);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            samples  = 0;
            frames   = 0;
            releases = 0;
        end else begin
            if (acc_m) begin
                samples++;
                if (samples % FL == 0) frames++;
            end
            if (rel_m) releases++;
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] llr,
                         input logic rel, input logic [7:0] da, input logic dc);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_llr = llr; frm_release = rel; dec_addr = da; dec_cs = dc;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_llr = '0; frm_release = 1'b0; dec_addr = '0; dec_cs = 1'b0;

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 8'd9, 0, 0, 0);
        check("reset_ready", in_ready, 0);
        check("reset_we0", ram_we[0], 0);
        drive(0, 0, 0, 0, 0, 0);
        check("ready_after_reset", in_ready, 1);

        // First frame into bank 0.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'(i), 0, 0, 0);
            check("b0_we", ram_we[0], 1);
            check("b0_addr", ram_addr[0], i);
            check("b0_data", ram_data[0], i);
        end
        drive(0, 0, 0, 0, 0, 0);
        check("frame0_valid", frm_valid, 1);
        check("frame0_bank", frm_bank, 0);

        // Bank 1 fills while the decoder reads bank 0.
        for (int i = 4; i < 8; i++) begin
            drive(0, 1, 8'(i), 0, 8'd2, 1);
            check("dec_addr0", ram_addr[0], 2);
            check("dec_cs0", ram_cs[0], 1);
            check("dec_we0", ram_we[0], 0);
            check("b1_we", ram_we[1], 1);
            check("b1_addr", ram_addr[1], i - 4);
        end
        drive(0, 1, 8'd8, 0, 0, 0);
        check("both_held_ready", in_ready, 0);
        check("stalled_we1", ram_we[1], 0);
        drive(0, 1, 8'd8, 1, 0, 0);
        check("release_cycle_ready", in_ready, 0);

        // Saturation / conversion values into bank 0.
        drive(0, 1, 8'd100, 0, 0, 0);
        check("ready_after_release", in_ready, 1);
        check("bank_after_release", frm_bank, 1);
        check("p100_data", ram_data[0], EXP_P100);
        drive(0, 1, 8'h9C, 0, 0, 0);
        check("m100_data", ram_data[0], EXP_M100);
        drive(0, 1, 8'hF0, 0, 0, 0);
        check("m16_data", ram_data[0], EXP_M16);
        drive(0, 1, 8'd3, 1, 0, 0);
        check("last_b0_addr", ram_addr[0], 3);
        drive(0, 0, 0, 0, 0, 0);
        check("swap_to_b0_valid", frm_valid, 1);
        check("swap_to_b0_bank", frm_bank, 0);

        // Last accept into bank 1 together with release of bank 0.
        for (int i = 0; i < 3; i++) drive(0, 1, 8'(20 + i), 0, 0, 0);
        drive(0, 1, 8'd23, 1, 0, 0);
        check("last_b1_we", ram_we[1], 1);
        check("last_b1_addr", ram_addr[1], 3);
        drive(0, 0, 0, 0, 0, 0);
        check("sim_bank", frm_bank, 1);
        check("sim_valid", frm_valid, 1);

        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("empty_valid", frm_valid, 0);
        check("empty_bank", frm_bank, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("ignored_release_bank", frm_bank, 0);

        // Hold a frame in bank 0, partially fill bank 1, then reset.
        for (int i = 0; i < 4; i++) drive(0, 1, 8'(30 + i), 0, 8'd1, 1);
        drive(0, 1, 8'd40, 0, 8'd1, 1);
        drive(0, 1, 8'd41, 0, 8'd1, 1);
        check("pre_reset_valid", frm_valid, 1);
        drive(1, 0, 0, 0, 8'd1, 1);
        check("reset_mid_valid", frm_valid, 0);
        check("reset_mid_cs0", ram_cs[0], 0);
        check("reset_mid_addr0", ram_addr[0], 0);
        drive(0, 1, 8'd7, 0, 0, 0);
        check("post_reset_we0", ram_we[0], 1);
        check("post_reset_addr0", ram_addr[0], 0);
        check("post_reset_data0", ram_data[0], 7);
        check("post_reset_we1", ram_we[1], 0);
        drive(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
